spi_bus_arbiter: RTL and testbench
==================================

Name: spi_bus_arbiter

Overview:
- Shares one 3-wire SPI bus (sck/sdo/sdi) between NREQ configuration clients: ADC1 and ADC2 (LTC2195) and DAC1 (AD9783) drivers.
- Each client gets its own active-low chip select.
- Pending requests are queued per client, granted round-robin, and serialized in SPI mode 0 (MSB first).
- Sits in the top level between the converter drivers' command ports and the shared adc/dac SPI pins, replacing ad-hoc sharing of sck/sdi.

Parameters:
- NREQ, 3, number of requesting clients (1..8).
- FRAME_W, 16, bits per SPI frame (address+data as one word).
- CLKDIV, 80, SCK period in clk_in cycles; even, >=4. H = CLKDIV/2 is the half period.
- GAP_H, 1, minimum CS-high time between frames, in half periods (>=1).

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- req_trig_in  in  NREQ  per-client single-cycle request strobe.
- req_frame_in  in  NREQ*FRAME_W  per-client frame; client i occupies bits [i*FRAME_W +: FRAME_W].
- req_busy_out  out  NREQ  client request pending or in flight.
- req_done_out  out  NREQ  one-cycle pulse when the client's frame completes.
- rdata_out  out  FRAME_W  word shifted in during the last completed frame.
- rdata_id_out  out  3  client index of rdata_out.
- spi_scs_out  out  NREQ  per-client chip select, active-low.
- spi_sck_out  out  1  shared SCK; idles low.
- spi_sdo_out  out  1  shared MOSI.
- spi_sdi_in  in  1  shared MISO.

Behaviour:
- Reset (async assert, sync release):
  - spi_scs_out all 1; spi_sck_out 0; spi_sdo_out 0.
  - req_busy_out and req_done_out all 0.
  - rdata_out 0; rdata_id_out 0.
  - Pending flags and frame latches cleared.
  - Round-robin pointer set so that client 0 has highest priority.
- Request latch:
  - trig[i] at edge T with busy[i]=0: latch frame, busy[i]=1 from T+1.
  - trig[i] while busy[i]=1: ignored; frame not overwritten.
- Arbitration (IDLE only):
  - Search the pending clients starting at last_grant+1, modulo NREQ.
  - The first pending client wins.
  - Simultaneous triggers are served in rotating order, never dropped.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE -> SETUP when any request is pending.
    - CS[g] falls on the next edge; with an idle bus this is 2 cycles after the trig edge.
    - spi_sdo_out = MSB on the same edge.
  - SETUP: H cycles, SCK low.
  - SHIFT: FRAME_W SCK periods, each H high then H low.
    - sdo updates on every SCK falling edge except the last.
    - sdi sampled on the clk edge that drives SCK high.
  - HOLD: H cycles, SCK low, CS still low.
  - At the end of HOLD:
    - CS[g] rises; done[g] pulses for 1 cycle; busy[g] clears.
    - rdata_out and rdata_id_out update on the same edge.
    - Go to GAP.
  - GAP: GAP_H*H cycles, all CS high, then IDLE.
- CS-low duration: (2*FRAME_W+2)*H cycles exactly. Only one CS is ever low.
- A trig[i] from a client whose own done pulse is in the same cycle is accepted: busy stays 1 and the new frame is latched.
- Counters:
  - Half-period counter is ceil(log2(H)) bits.
  - Bit counter is ceil(log2(FRAME_W+1)) bits.
  - No wrap-around is permitted within a frame.
- Reset mid-frame: CS released and SCK forced low immediately (async); pending requests lost; no done pulse.

Optional Feature:
- Macro: SPI_READBACK_EN.
- Defined: sdi shift register present; rdata_out and rdata_id_out behave as above.
- Undefined: sdi ignored; rdata_out and rdata_id_out held at 0; shift-in logic removed.

Decomposition:
- Package spi_arb_pkg:
  - FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP).
  - Default FRAME_W and CLKDIV constants.
  - Client index constants CLI_ADC1=0, CLI_ADC2=1, CLI_DAC1=2.
- Sub-module spi_shift_engine:
  - Contents: SETUP/SHIFT/HOLD timing, sck/sdo generation, sdi capture.
  - Handshake: start/frame in, done/rdata out.
- Arbiter top keeps: pending flags, frame latches, round-robin pointer, CS decode, GAP.

Test Plan:
- CLKDIV=8, idle bus, trig[0] with frame 0x8A5C:
  - CS[0] falls 2 cycles after trig.
  - 16 SCK rising edges; sdo = 1000_1010_0101_1100 on the rising edges.
  - CS low for 136 cycles; done[0] pulses once.
- trig[0..2] in the same cycle with frames 0x1111/0x2222/0x3333:
  - Frames run in order 0, 1, 2.
  - Every gap between frames has CS high for >=4 cycles.
  - busy bits clear one per done.
- trig[1]=0x0F0F, then trig[1]=0xFFFF during SHIFT:
  - Second trig ignored; exactly one frame sent, 0x0F0F.
- With SPI_READBACK_EN, sdi driven with 0xC3A5 MSB-first on the rising edges:
  - rdata_out = 0xC3A5 and rdata_id_out = client index, at done.
  - Without the macro, rdata_out stays 0.
- rst_n_in low at bit 7 of a frame:
  - CS all 1 and SCK 0 in the same cycle; busy all 0; no done pulse.
  - After release, a fresh trig[2] is served by client 2 normally.
- Fairness: client 0 re-triggers on every done while client 1 is pending:
  - Grants alternate 0, 1, 0, 1; client 1 never starves.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter.
// FSM state encoding, default frame/clock sizing, client indices.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } arb_state_t;

  localparam int DEF_FRAME_W = 16;
  localparam int DEF_CLKDIV  = 80;

  localparam int CLI_ADC1 = 0;
  localparam int CLI_ADC2 = 1;
  localparam int CLI_DAC1 = 2;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 frame engine: SETUP/SHIFT/HOLD timing, sck/sdo, sdi capture.
// Ports: start/frame in, done (end of HOLD, comb)/rdata out, sck/sdo/sdi.
// SPI_READBACK_EN: when undefined, sdi is ignored and rdata is 0.
module spi_shift_engine
  import spi_arb_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int CLKDIV  = DEF_CLKDIV
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  input  logic               sdi,
  output logic               done,
  output logic [FRAME_W-1:0] rdata,
  output logic               sck,
  output logic               sdo
);
  localparam int H   = CLKDIV / 2;
  localparam int HCW = $clog2(H);
  localparam int BCW = $clog2(FRAME_W + 1);
  localparam logic [HCW-1:0] HLAST = HCW'(H - 1);
  localparam logic [BCW-1:0] BLAST = BCW'(FRAME_W - 1);
  localparam logic [BCW-1:0] BEND  = BCW'(FRAME_W);

  arb_state_t         st;
  logic [HCW-1:0]     hcnt;
  logic [BCW-1:0]     bcnt;
  logic [FRAME_W-1:0] tx_sr;
  logic               hend;

  assign hend = (hcnt == HLAST);
  assign done = (st == HOLD) && hend;
  assign sdo  = tx_sr[FRAME_W-1];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st    <= IDLE;
      hcnt  <= '0;
      bcnt  <= '0;
      sck   <= 1'b0;
      tx_sr <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (start) begin
            st    <= SETUP;
            hcnt  <= '0;
            bcnt  <= '0;
            tx_sr <= frame;
          end
        end
        SETUP: begin
          if (hend) begin
            st   <= SHIFT;
            hcnt <= '0;
            sck  <= 1'b1;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        SHIFT: begin
          if (!hend) begin
            hcnt <= hcnt + 1'b1;
          end else begin
            hcnt <= '0;
            if (sck) begin
              sck  <= 1'b0;
              bcnt <= bcnt + 1'b1;
              // last bit stays on sdo through the final low half
              if (bcnt != BLAST)
                tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
            end else if (bcnt == BEND) begin
              st <= HOLD;
            end else begin
              sck <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (hend) st <= IDLE;
          else hcnt <= hcnt + 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic               rise;
  logic [FRAME_W-1:0] rx_sr;

  // clk edges that drive sck high
  assign rise = hend && ((st == SETUP) ||
                ((st == SHIFT) && !sck && (bcnt != BEND)));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rx_sr <= '0;
    else if (rise) rx_sr <= {rx_sr[FRAME_W-2:0], sdi};
  end

  assign rdata = rx_sr;
`else
  logic unused_sdi;
  assign unused_sdi = sdi;
  assign rdata      = '0;
`endif

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI bus between NREQ clients.
// Ports: clk_in, rst_n_in, req_* per client, rdata*, spi_scs/sck/sdo/sdi.
// SPI_READBACK_EN: enables rdata_out/rdata_id_out capture of sdi.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int CLKDIV  = DEF_CLKDIV,
  parameter int GAP_H   = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NREQ-1:0]         req_trig_in,
  input  logic [NREQ*FRAME_W-1:0] req_frame_in,
  output logic [NREQ-1:0]         req_busy_out,
  output logic [NREQ-1:0]         req_done_out,
  output logic [FRAME_W-1:0]      rdata_out,
  output logic [2:0]              rdata_id_out,
  output logic [NREQ-1:0]         spi_scs_out,
  output logic                    spi_sck_out,
  output logic                    spi_sdo_out,
  input  logic                    spi_sdi_in
);
  localparam int H   = CLKDIV / 2;
  localparam int GL  = GAP_H * H;
  localparam int GCW = $clog2(GL);
  localparam logic [GCW-1:0] GLAST = GCW'(GL - 1);

  arb_state_t         st;
  logic [2:0]         last_q;
  logic [2:0]         win;
  logic               win_ok;
  int                 idx;
  logic [NREQ-1:0]    pend_q;
  logic [NREQ-1:0]    cs_n_q;
  logic [NREQ-1:0]    done_q;
  logic [NREQ-1:0]    fin_oh;
  logic [FRAME_W-1:0] frm_q [NREQ];
  logic [GCW-1:0]     gcnt;
  logic               start;
  logic               fin;
  logic [FRAME_W-1:0] eng_rdata;

  // first pending client after the last grant wins
  always_comb begin
    win_ok = 1'b0;
    win    = last_q;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!win_ok && pend_q[idx]) begin
        win_ok = 1'b1;
        win    = 3'(idx);
      end
    end
  end

  assign start  = (st == IDLE) && win_ok;
  assign fin_oh = fin ? ~cs_n_q : '0;

  spi_shift_engine #(
    .FRAME_W (FRAME_W),
    .CLKDIV  (CLKDIV)
  ) u_eng (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start    (start),
    .frame    (frm_q[win]),
    .sdi      (spi_sdi_in),
    .done     (fin),
    .rdata    (eng_rdata),
    .sck      (spi_sck_out),
    .sdo      (spi_sdo_out)
  );

  // a trigger landing on the client's own done edge is re-accepted
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pend_q <= '0;
      for (int i = 0; i < NREQ; i++) frm_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_trig_in[i] && (!pend_q[i] || fin_oh[i])) begin
          pend_q[i] <= 1'b1;
          frm_q[i]  <= req_frame_in[i*FRAME_W +: FRAME_W];
        end else if (fin_oh[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  // SHIFT spans the whole CS-low window; the engine sequences inside it
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st     <= IDLE;
      last_q <= 3'(NREQ - 1);
      cs_n_q <= '1;
      gcnt   <= '0;
      done_q <= '0;
    end else begin
      done_q <= fin_oh;
      unique case (st)
        IDLE: begin
          if (win_ok) begin
            st     <= SHIFT;
            last_q <= win;
            cs_n_q <= ~(NREQ'(1) << win);
          end
        end
        SHIFT: begin
          if (fin) begin
            st     <= GAP;
            cs_n_q <= '1;
            gcnt   <= '0;
          end
        end
        GAP: begin
          if (gcnt == GLAST) st <= IDLE;
          else gcnt <= gcnt + 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [FRAME_W-1:0] rdata_q;
  logic [2:0]         rid_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdata_q <= '0;
      rid_q   <= '0;
    end else if (fin) begin
      rdata_q <= eng_rdata;
      rid_q   <= last_q;
    end
  end

  assign rdata_out    = rdata_q;
  assign rdata_id_out = rid_q;
`else
  logic unused_rd;
  assign unused_rd    = ^eng_rdata;
  assign rdata_out    = '0;
  assign rdata_id_out = '0;
`endif

  assign req_busy_out = pend_q;
  assign req_done_out = done_q;
  assign spi_scs_out  = cs_n_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter (NREQ=3, FRAME_W=16, CLKDIV=8).
// Frames are checked on CS rise against expectations queued at trigger time.
module tb_spi_bus_arbiter;
  localparam int N  = 3;
  localparam int W  = 16;
  localparam int CD = 8;

  logic          clk = 0;
  logic          rst_n = 0;
  logic [N-1:0]  trig = '0;
  logic [N*W-1:0] frames = '0;
  logic [N-1:0]  busy, done, cs;
  logic [W-1:0]  rdata;
  logic [2:0]    rid;
  logic          sck, sdo;
  logic          sdi = 0;

  spi_bus_arbiter #(
    .NREQ (N), .FRAME_W (W), .CLKDIV (CD), .GAP_H (1)
  ) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .req_trig_in  (trig),
    .req_frame_in (frames),
    .req_busy_out (busy),
    .req_done_out (done),
    .rdata_out    (rdata),
    .rdata_id_out (rid),
    .spi_scs_out  (cs),
    .spi_sck_out  (sck),
    .spi_sdo_out  (sdo),
    .spi_sdi_in   (sdi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [W-1:0] frame;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_frames = 0;
  int abort_req = 0;
  int abort_done = 0;
  int rises = 0;
  logic [W-1:0] sdi_pat = 16'hC3A5;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // bus monitor, sampled on the falling clk edge
  int low_cnt = 0;
  int hi_cnt = 0;
  int cur_id = 0;
  bit prev_low = 0;
  bit prev_sck = 0;
  bit had_frame = 0;
  logic [W-1:0] sdo_acc = '0;

  always @(negedge clk) begin
    bit cur_low;
    exp_t e;
    cur_low = (cs != '1);
    if (cur_low && !prev_low) begin
      check("cs_onehot", $countones(~cs), 1);
      if (had_frame) check("gap_ge4", 32'(hi_cnt >= 4), 1);
      low_cnt = 1;
      rises = 0;
      sdo_acc = '0;
      for (int i = 0; i < N; i++) if (!cs[i]) cur_id = i;
      sdi = sdi_pat[W-1];
    end else if (cur_low) begin
      low_cnt++;
      if (sck && !prev_sck) begin
        sdo_acc = {sdo_acc[W-2:0], sdo};
        rises++;
        if (rises < W) sdi = sdi_pat[W-1-rises];
      end
    end
    if (!cur_low && prev_low) begin
      if (abort_req != abort_done) begin
        abort_done = abort_req;
        check("abort_no_done", 32'(done), 0);
        if (sbq.size() > 0) void'(sbq.pop_front());
      end else if (sbq.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        e = sbq.pop_front();
        n_frames++;
        check("frame_id", cur_id, e.id);
        check("frame_sdo", 32'(sdo_acc), 32'(e.frame));
        check("sck_rises", rises, W);
        check("cs_low_len", low_cnt, 136);
        check("done_pulse", 32'(done), 32'(1 << e.id));
`ifdef SPI_READBACK_EN
        check("rdata", 32'(rdata), 32'(sdi_pat));
        check("rdata_id", 32'(rid), e.id);
`else
        check("rdata_zero", 32'(rdata), 0);
        check("rdata_id_zero", 32'(rid), 0);
`endif
      end
      hi_cnt = 1;
      had_frame = 1;
    end else if (!cur_low) begin
      hi_cnt++;
    end
    prev_low = cur_low;
    prev_sck = sck;
  end

  task automatic send(int id, logic [W-1:0] f, bit push);
    exp_t e;
    @(posedge clk);
    #1;
    trig[id] = 1'b1;
    frames[id*W +: W] = f;
    if (push) begin
      e.id = id;
      e.frame = f;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    trig = '0;
  endtask

  task automatic wait_done(int id);
    bit seen = 0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done[id]) seen = 1;
    end
    if (!seen) check("done_timeout", id, 32'hFFFF);
  endtask

  task automatic wait_cs_low(int id);
    bit seen = 0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (!cs[id]) seen = 1;
    end
    if (!seen) check("cs_timeout", id, 32'hFFFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n;
    int f0;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 32'(cs), 32'h7);
    check("rst_sck", 32'(sck), 0);
    check("rst_sdo", 32'(sdo), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_rid", 32'(rid), 0);
    rst_n = 1;

    // single frame, latency from trigger to CS fall
    @(posedge clk);
    #1;
    trig[0] = 1'b1;
    frames[0 +: W] = 16'h8A5C;
    e.id = 0;
    e.frame = 16'h8A5C;
    sbq.push_back(e);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      trig = '0;
      n++;
      if (!cs[0]) break;
    end
    check("cs_fall_lat", n, 2);
    check("busy_in_flight", 32'(busy), 1);
    wait_done(0);
    check("busy_after_done", 32'(busy), 0);

    // retrigger while busy is ignored
    send(1, 16'h0F0F, 1);
    wait_cs_low(1);
    repeat (40) @(posedge clk);
    f0 = n_frames;
    send(1, 16'hFFFF, 0);
    wait_done(1);
    repeat (200) @(posedge clk);
    check("single_frame", n_frames - f0, 1);

    // reset mid-frame
    send(2, 16'h1234, 1);
    for (int k = 0; k < 500 && rises != 7; k++) @(posedge clk);
    check("reach_bit7", rises, 7);
    @(posedge clk);
    #2;
    abort_req++;
    rst_n = 0;
    #1;
    check("mid_rst_cs", 32'(cs), 32'h7);
    check("mid_rst_sck", 32'(sck), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    send(2, 16'h5AA5, 1);
    wait_done(2);

    // simultaneous triggers after reset: order 0,1,2
    @(posedge clk);
    #1;
    trig = 3'b111;
    frames = {16'h3333, 16'h2222, 16'h1111};
    for (int i = 0; i < N; i++) begin
      e.id = i;
      e.frame = frames[i*W +: W];
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    trig = '0;
    wait_done(0);
    check("busy_step1", 32'(busy), 32'b110);
    wait_done(1);
    check("busy_step2", 32'(busy), 32'b100);
    wait_done(2);
    check("busy_step3", 32'(busy), 32'b000);

    // fairness: 0 retriggers on its own done edge while 1 waits
    send(0, 16'hA0A0, 1);
    wait_cs_low(0);
    @(posedge clk);
    #1;
    trig[1] = 1'b1;
    frames[W +: W] = 16'hB1B1;
    e.id = 1;
    e.frame = 16'hB1B1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    trig = '0;
    repeat (133) @(posedge clk);
    #1;
    trig[0] = 1'b1;
    frames[0 +: W] = 16'hC0C0;
    e.id = 0;
    e.frame = 16'hC0C0;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    trig = '0;
    check("same_edge_done", 32'(done), 1);
    check("same_edge_busy", 32'(busy[0]), 1);
    wait_done(1);
    send(1, 16'hD1D1, 1);
    wait_done(0);
    wait_done(1);

    repeat (20) @(posedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
